// File: rtl/rand_pkg.sv
// Shared types and constants for the LFSR seed/arbitration controller.
// Holds the controller state encoding and the seed zero-fix helper.
package rand_pkg;

  localparam int RND_W = 32;
  localparam int GAP_W = 8;
  localparam logic [RND_W-1:0] SEED_ZERO_FIX = 32'h1;

  typedef enum logic [2:0] {
    UNSEEDED,
    LOAD,
    WARM,
    IDLE,
    GAP
  } state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by a fixed non-zero word.
  function automatic logic [RND_W-1:0] fix_seed(input logic [RND_W-1:0] v);
    return (v == '0) ? SEED_ZERO_FIX : v;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or after ptr_i, wrapping modulo N.
// Zero latency; found_o low when no request is set.
module rr_picker #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W:0] pos;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(N)) begin
        pos = pos - (IDX_W+1)'(N);
      end
      if (!found_o && req_i[pos[IDX_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/random_arbiter.sv
// Seeds the shared LFSR from a free-running counter on the first user event, then round-robins it with a decorrelation gap.
// Optional RANDOM_LOCKUP_CHECK_EN: reseed when the LFSR reads all-zero and expose a sticky lockup_o flag.
module random_arbiter
  import rand_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int STRIDE = 32,
  parameter int WARMUP = 32,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_evt_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] ack_o,
  output logic [IDX_W-1:0] gnt_id_o,
  output logic [RND_W-1:0] rnd_o,
  output logic             ready_o,
  output logic [RND_W-1:0] seed_o,
  output logic             seed_v_o,
  input  logic [RND_W-1:0] random_i
`ifdef RANDOM_LOCKUP_CHECK_EN
  ,
  output logic             lockup_o
`endif
);

  state_t             state_q, state_d;
  logic [RND_W-1:0]   fc_q, fc_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
  logic [RND_W-1:0]   rnd_q, rnd_d;
  logic [RND_W-1:0]   seed_q, seed_d;
  logic               seed_v_q, seed_v_d;
`ifdef RANDOM_LOCKUP_CHECK_EN
  logic               lockup_q, lockup_d;
`endif

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic               ready;
  logic               reseed;
  logic               lock_hit;

  rr_picker #(.N(N_REQ)) u_picker (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .found_o (pick_vld),
    .idx_o   (pick_idx)
  );

  assign ready  = (state_q == IDLE) || (state_q == GAP);
  assign reseed = seed_evt_i && (state_q != LOAD);

`ifdef RANDOM_LOCKUP_CHECK_EN
  assign lock_hit = ready && (random_i == '0);
`else
  assign lock_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    fc_d     = fc_q + RND_W'(1);
    gap_d    = gap_q;
    ptr_d    = ptr_q;
    ack_d    = '0;
    gnt_id_d = gnt_id_q;
    seed_d   = seed_q;
    seed_v_d = 1'b0;
    rnd_d    = (|ack_q) ? random_i : rnd_q;
`ifdef RANDOM_LOCKUP_CHECK_EN
    lockup_d = lockup_q;
`endif

    case (state_q)
      UNSEEDED: ;
      LOAD: begin
        gap_d   = GAP_W'(WARMUP);
        state_d = WARM;
      end
      WARM, GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (pick_vld) begin
          ack_d[pick_idx] = 1'b1;
          gnt_id_d        = pick_idx;
          ptr_d           = (pick_idx == IDX_W'(N_REQ-1)) ? '0 : pick_idx + IDX_W'(1);
          gap_d           = GAP_W'(STRIDE);
          state_d         = GAP;
        end
      end
      default: state_d = UNSEEDED;
    endcase

    // A reseed (user event or LFSR lockup) pre-empts any grant decided this cycle.
    if (reseed || lock_hit) begin
      state_d  = LOAD;
      ack_d    = '0;
      gnt_id_d = gnt_id_q;
      ptr_d    = ptr_q;
      gap_d    = gap_q;
      seed_v_d = 1'b1;
      seed_d   = lock_hit ? (fc_q | SEED_ZERO_FIX) : fix_seed(fc_q);
`ifdef RANDOM_LOCKUP_CHECK_EN
      lockup_d = lockup_q | lock_hit;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= UNSEEDED;
      fc_q     <= '0;
      gap_q    <= '0;
      ptr_q    <= '0;
      ack_q    <= '0;
      gnt_id_q <= '0;
      rnd_q    <= '0;
      seed_q   <= '0;
      seed_v_q <= 1'b0;
`ifdef RANDOM_LOCKUP_CHECK_EN
      lockup_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      fc_q     <= fc_d;
      gap_q    <= gap_d;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      gnt_id_q <= gnt_id_d;
      rnd_q    <= rnd_d;
      seed_q   <= seed_d;
      seed_v_q <= seed_v_d;
`ifdef RANDOM_LOCKUP_CHECK_EN
      lockup_q <= lockup_d;
`endif
    end
  end

  assign ack_o    = ack_q;
  assign gnt_id_o = gnt_id_q;
  // The word is handed out live in the ack cycle and frozen afterwards.
  assign rnd_o    = (|ack_q) ? random_i : rnd_q;
  assign ready_o  = ready;
  assign seed_o   = seed_q;
  assign seed_v_o = seed_v_q;
`ifdef RANDOM_LOCKUP_CHECK_EN
  assign lockup_o = lockup_q;
`endif

endmodule

// File: tb/tb_random_arbiter.sv
// Scoreboard bench for random_arbiter: a cycle-stamped reference model queues expected seeds/acks, a negedge monitor compares.
// Build with RANDOM_LOCKUP_CHECK_EN defined to also exercise the lockup reseed.
module tb_random_arbiter;
  import rand_pkg::*;

  localparam int N      = 4;
  localparam int STRIDE = 32;
  localparam int WARMUP = 32;
  localparam int IDX_W  = $clog2(N);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             seed_evt = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     ack;
  logic [IDX_W-1:0] gnt_id;
  logic [31:0]      rnd_out;
  logic             ready;
  logic [31:0]      seed;
  logic             seed_v;
  logic [31:0]      rnd_in = 32'h1;
`ifdef RANDOM_LOCKUP_CHECK_EN
  logic             lockup;
`endif

  random_arbiter #(.N_REQ(N), .STRIDE(STRIDE), .WARMUP(WARMUP)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_evt_i (seed_evt),
    .req_i      (req),
    .ack_o      (ack),
    .gnt_id_o   (gnt_id),
    .rnd_o      (rnd_out),
    .ready_o    (ready),
    .seed_o     (seed),
    .seed_v_o   (seed_v),
    .random_i   (rnd_in)
`ifdef RANDOM_LOCKUP_CHECK_EN
    ,
    .lockup_o   (lockup)
`endif
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; equals the DUT's free-running counter.
  int cyc = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } ev_t;

  ev_t ack_exp[$];
  ev_t seed_exp[$];

  // Reference model: arbiter availability expressed as cycle numbers.
  bit          m_seeded;
  int          m_load_cyc;
  int          m_rdy_from;
  int          m_free_at;
  int          m_ptr;
  int          m_lock_cyc;
  int          m_grants = 0;
  bit          exp_rdy;
  logic [31:0] last_rnd;

  task automatic model_flush();
    ack_exp.delete();
    seed_exp.delete();
    m_seeded   = 1'b0;
    m_load_cyc = -1;
    m_rdy_from = 0;
    m_free_at  = 0;
    m_ptr      = 0;
    m_lock_cyc = -1;
    exp_rdy    = 1'b0;
    last_rnd   = '0;
  endtask

  task automatic model_step(input bit s, input logic [N-1:0] r, input logic [31:0] x);
    int          c;
    bit          lock;
    bit          found;
    logic [31:0] sv;
    c       = cyc;
    exp_rdy = m_seeded && (c >= m_rdy_from);
    lock    = 1'b0;
`ifdef RANDOM_LOCKUP_CHECK_EN
    lock = exp_rdy && (x == 32'h0);
`endif
    if (lock || (s && !(m_seeded && c == m_load_cyc))) begin
      sv = lock ? (32'(c) | 32'h1) : ((c == 0) ? 32'h1 : 32'(c));
      seed_exp.push_back('{c + 1, sv});
      if (lock && m_lock_cyc < 0) m_lock_cyc = c + 1;
      m_seeded   = 1'b1;
      m_load_cyc = c + 1;
      m_rdy_from = c + WARMUP + 2;
      m_free_at  = m_rdy_from;
    end else if (m_seeded && c >= m_free_at && r != '0) begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (!found && r[k]) begin
          found = 1'b1;
          ack_exp.push_back('{c + 1, 32'(k)});
          m_ptr     = (k + 1) % N;
          m_free_at = c + STRIDE + 1;
          m_grants++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      ev_t e;
      check("ready", 32'(ready), 32'(exp_rdy));
      if (seed_exp.size() != 0 && seed_exp[0].cyc == cyc) begin
        e = seed_exp.pop_front();
        check("seed_v", 32'(seed_v), 32'h1);
        check("seed_val", seed, e.val);
      end else begin
        check("seed_v_idle", 32'(seed_v), 32'h0);
      end
      if (ack_exp.size() != 0 && ack_exp[0].cyc == cyc) begin
        e = ack_exp.pop_front();
        check("ack_vec", 32'(ack), 32'h1 << e.val);
        check("gnt_id", 32'(gnt_id), e.val);
        check("rnd_live", rnd_out, rnd_in);
        last_rnd = rnd_in;
      end else begin
        check("ack_idle", 32'(ack), 32'h0);
        check("rnd_hold", rnd_out, last_rnd);
      end
`ifdef RANDOM_LOCKUP_CHECK_EN
      check("lockup", 32'(lockup), 32'(m_lock_cyc >= 0 && cyc >= m_lock_cyc));
`endif
    end
  end

  function automatic logic [31:0] rnd();
    return $urandom() | 32'h100;
  endfunction

  task automatic tick(input bit s, input logic [N-1:0] r, input logic [31:0] x);
    seed_evt = s;
    req      = r;
    rnd_in   = x;
    model_step(s, r, x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    seed_evt = 1'b0;
    req      = '0;
    model_flush();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_until_grants(input int target, input logic [N-1:0] r, input int budget);
    int n;
    n = 0;
    while (m_grants < target && n < budget) begin
      tick(1'b0, r, rnd());
      n++;
    end
    check("grant_timeout", 32'(m_grants), 32'(target));
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (!(m_seeded && cyc >= m_free_at) && n < budget) begin
      tick(1'b0, '0, rnd());
      n++;
    end
    check("idle_timeout", 32'(m_seeded && cyc >= m_free_at), 32'h1);
  endtask

  initial begin
    int n;
    model_flush();
    do_reset();

    // Unseeded: requests are ignored, nothing is granted or loaded.
    repeat (100) tick(1'b0, '1, rnd());

    // Seed at free counter 0 must load the zero-fix value.
    do_reset();
    tick(1'b1, '0, rnd());

    // All requesting: 0,1,2,3,0,1,2 leaves the pointer at 3.
    run_until_grants(7, 4'b1111, 400);
    // Wrap search from pointer 3 finds requester 2, then 3 is next.
    run_until_grants(8, 4'b0100, 100);
    run_until_grants(9, 4'b1111, 100);

    // Reseed in the cycle a grant would be issued.
    run_until_idle(100);
    tick(1'b1, 4'b1000, rnd());
    run_until_grants(10, 4'b1000, 200);

    // Random traffic with occasional reseeds.
    repeat (1500) tick($urandom_range(0, 199) == 0, N'($urandom()), rnd());

    // Async reset in an ack cycle clears all outputs immediately.
    n = 0;
    while (!(ack_exp.size() != 0 && ack_exp[0].cyc == cyc) && n < 300) begin
      tick(1'b0, '1, rnd());
      n++;
    end
    check("ack_wait_timeout", 32'(ack_exp.size() != 0 && ack_exp[0].cyc == cyc), 32'h1);
    #1;
    rst = 1'b0;
    #1;
    check("arst_ack", 32'(ack), 32'h0);
    check("arst_gnt_id", 32'(gnt_id), 32'h0);
    check("arst_rnd", rnd_out, 32'h0);
    check("arst_ready", 32'(ready), 32'h0);
    check("arst_seed", seed, 32'h0);
    check("arst_seed_v", 32'(seed_v), 32'h0);
    do_reset();
    tick(1'b1, '0, rnd());
    run_until_grants(m_grants + 2, 4'b1111, 200);

`ifdef RANDOM_LOCKUP_CHECK_EN
    // All-zero LFSR word in IDLE forces an odd reseed and sets the sticky flag.
    run_until_idle(100);
    tick(1'b0, 4'b0001, 32'h0);
    repeat (60) tick(1'b0, '0, rnd());
    run_until_grants(m_grants + 1, 4'b0001, 200);
`endif

    repeat (STRIDE + 4) tick(1'b0, '0, rnd());
    check("pending_acks", 32'(ack_exp.size()), 32'h0);
    check("pending_seeds", 32'(seed_exp.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
